// File: rtl/arbiter4_rr.sv
// arbiter4_rr: four-client round-robin arbiter, registered one-hot grant
// plus binary index; grant held while owner requests, no preemption.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset
//   req[3:0]   in   level requests, req[k] = client k
//   gnt[3:0]   out  one-hot grant (registered)
//   gnt_idx    out  binary index of granted client, 0 when idle
//   gnt_valid  out  high when gnt != 0
//   expired    out  one-cycle pulse when hold limit revokes a grant
//
// Build option: define ARB_HOLD_LIMIT_EN to cap each ownership at
// HOLD_MAX consecutive grant cycles. Without it, expired is tied low.
module arbiter4_rr #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       expired
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("arbiter4_rr: HOLD_MAX must be in 2..255");
    end

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       exp_q, exp_d;
`endif

    // Rotating scan: first requester at or after ptr, wrapping at 3.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        win   = ptr_q;
        found = 1'b0;
        cand  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d   = cnt_q;
        exp_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << win;
                    idx_d   = win;
                    ptr_d   = win + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            S_GRANT: begin
                // Voluntary release wins over the hold limit.
                if (!req[idx_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'b00;
`ifdef ARB_HOLD_LIMIT_EN
                // cnt_q counts completed grant cycles before this one,
                // so HOLD_MAX-1 means this is the last allowed cycle.
                end else if (cnt_q == 8'(HOLD_MAX - 1)) begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'b00;
                    exp_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'b00;
            ptr_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign expired = exp_q;
`else
    assign expired = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == S_GRANT);

endmodule
